// File: rtl/uart_fifo_tx.sv
// FIFO-draining UART transmitter, 8N1/8N2. Frame is (1+DATA_SIZE+STOP_BITS)*CLKS_PER_BIT clks; pops only from IDLE.
// Optional even parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_fifo_tx #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 10417,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_SIZE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity, parity_n;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic [BW-1:0]        baud, baud_n;
  logic [CW-1:0]        bit_cnt, bit_n;
  logic [DATA_SIZE-1:0] shreg, sh_n;
  logic                 tx_n, rd_n, busy_n, done_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      baud         <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      tx           <= 1'b1;
      fifo_read    <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity       <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      baud         <= baud_n;
      bit_cnt      <= bit_n;
      shreg        <= sh_n;
      tx           <= tx_n;
      fifo_read    <= rd_n;
      tx_busy      <= busy_n;
      tx_done_tick <= done_n;
`ifdef UART_TX_PARITY_EN
      parity       <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bit_n    = bit_cnt;
    sh_n     = shreg;
    tx_n     = tx;
    rd_n     = 1'b0;
    done_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n = parity;
`endif
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        bit_n  = '0;
        if (!fifo_empty) begin
          sh_n    = fifo_data;
          rd_n    = 1'b1;
          tx_n    = 1'b0;
          state_n = START;
`ifdef UART_TX_PARITY_EN
          parity_n = ^fifo_data;
`endif
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          sh_n   = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            tx_n    = parity;
            state_n = PARITY;
`else
            tx_n    = 1'b1;
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_cnt + 1'b1;
            tx_n  = sh_n[0];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        // Registered pulse: raise it one clk early so it lands on the final stop clk
        if (baud == BAUD_PRE && bit_cnt == STOP_LAST) done_n = 1'b1;
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n   = '0;
            state_n = IDLE;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
UART transmitter that drains the UART TX FIFO and serializes each byte onto the serial line as 8N1 frames (8N2 by parameter).
- Sits between the FIFO read side (empty flag, combinational read data, read strobe) and the board TX pin.
- Contains its own baud-rate counter, so no external tick generator is needed.
- Reader counterpart to the FIFO's write side, which is fed by the host or receive path.

Parameters:
DATA_SIZE, 8, bits per data word; must match the FIFO word width.
CLKS_PER_BIT, 10417, clk cycles per serial bit (100 MHz / 9600 baud); minimum 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  FPGA clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
fifo_empty  input  1  FIFO empty flag; registered in the FIFO.
fifo_data  input  DATA_SIZE  FIFO head word; valid whenever fifo_empty=0.
fifo_read  output  1  one-cycle pop strobe to the FIFO read request.
tx  output  1  serial output; idles high.
tx_busy  output  1  high whenever the state is not IDLE.
tx_done_tick  output  1  one-cycle pulse on the last clk of the final stop bit.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE; tx=1; tx_busy=0; fifo_read=0; tx_done_tick=0.
  - Baud counter and bit counter cleared.
  - Shift register cleared.
- All outputs are registered.
- States: IDLE, START, DATA, STOP (plus PARITY when PARITY_EN is defined).
- IDLE:
  - tx=1.
  - On the edge where fifo_empty=0:
    - load fifo_data into the shift register;
    - set fifo_read=1 for exactly one cycle after that edge;
    - drive tx=0 and go to START.
  - No pop when fifo_empty=1.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Send DATA_SIZE bits, LSB first, each held CLKS_PER_BIT cycles.
  - Shift right after each bit.
  - Bit counter runs 0..DATA_SIZE-1; after the last bit, go to STOP.
- STOP:
  - Hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done_tick=1 on the final cycle; then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Width is clog2(CLKS_PER_BIT).
- Frame timing: the frame occupies (1+DATA_SIZE+STOP_BITS)*CLKS_PER_BIT cycles from the load edge to re-entry into IDLE.
- Back-to-back frames:
  - IDLE lasts at least 1 cycle, so the inter-frame gap is exactly 1 clk of tx=1 when the FIFO stays non-empty.
  - Because fifo_read is single-cycle and only issued from IDLE, the registered empty flag has settled before the next sample; no double pop.
- fifo_empty and fifo_data are ignored outside IDLE. A FIFO write during a frame does not disturb the frame.
- Reset mid-frame:
  - tx returns high immediately; the in-flight byte is lost (it was already popped).
  - After reset deasserts, the next FIFO word starts a new frame from IDLE.

Optional Feature:
UART_TX_PARITY_EN.
- When defined:
  - a PARITY state is inserted between DATA and STOP;
  - it sends the even-parity bit (XOR of the loaded word) for CLKS_PER_BIT cycles;
  - frame length becomes (2+DATA_SIZE+STOP_BITS)*CLKS_PER_BIT.
- When undefined: no parity state; frame is exactly as in Behaviour.

Test Plan:
1. Reset with CLKS_PER_BIT=4 and fifo_empty=1 -> tx=1, tx_busy=0, fifo_read=0; after 100 cycles, still no fifo_read pulse.
2. Single byte 0xA5:
   - stimulus: fifo_empty drops with fifo_data=0xA5;
   - fifo_read is high for exactly 1 cycle;
   - tx sequence, 4 clk per bit: 0 | 1,0,1,0,0,1,0,1 | 1;
   - tx_done_tick fires on cycle 40 after the load edge;
   - tx_busy is high for 40 cycles.
3. Back-to-back 0x00, 0xFF, 0x55 preloaded in the FIFO -> three fifo_read pulses spaced 41 cycles apart; each frame is bit-exact; exactly 1 clk of tx=1 between each stop bit and the next start bit.
4. STOP_BITS=2 with byte 0x3C -> stop level lasts 8 cycles; tx_done_tick arrives 44 cycles after the load edge.
5. Reset pulse during DATA bit 3 of 0xA5 with 0x12 queued next:
   - tx=1 in the same cycle; tx_busy=0; no fifo_read while reset is high;
   - after release, the next frame carries 0x12.
6. UART_TX_PARITY_EN defined with byte 0x07 -> parity bit=1 appears after bit 7 for 4 cycles; frame is 44 cycles; with 0x03, parity bit=0.
